// File: rtl/mmult_seq.sv
// Sequencer for the systolic matrix-multiply datapath: walks the matrix in row or
// column order, steps the operand register halves and frames the MAC. Optional MMULT_STALLCNT_EN adds stall_cnt.
module mmult_seq #(
    parameter int AW    = 24,
    parameter int RW    = 5,
    parameter int DRAIN = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [AW-1:0] mtxa,
    input  logic          mtxc_col,
    input  logic [3:0]    mwidth,
    input  logic [RW-1:0] rbase,
    input  logic          count1,
    input  logic          mem_ack,
    output logic          cntld,
    output logic          cnten,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [RW-1:0] ridx,
    output logic          rsel_hi,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          busy,
    output logic          done
`ifdef MMULT_STALLCNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [RW-1:0]   ridx_q, ridx_d;
    logic            rsel_q, rsel_d;
    logic [6:0]      step_q, step_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic [4:0]      elems;

    // mwidth of 0 encodes a full 16-element row/column
    assign elems = (mwidth == 4'd0) ? 5'd16 : {1'b0, mwidth};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            ridx_q  <= '0;
            rsel_q  <= 1'b0;
            step_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ridx_q  <= ridx_d;
            rsel_q  <= rsel_d;
            step_q  <= step_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ridx_d  = ridx_q;
        rsel_d  = rsel_q;
        step_d  = step_q;
        drain_d = drain_q;
        cntld   = 1'b0;
        cnten   = 1'b0;
        mem_req = 1'b0;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        done    = 1'b0;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    addr_d  = mtxa & {{(AW-2){1'b1}}, 2'b00};
                    ridx_d  = rbase;
                    rsel_d  = 1'b0;
                    step_d  = mtxc_col ? {elems, 2'b00} : 7'd4;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cntld   = 1'b1;
                mac_clr = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    cnten  = 1'b1;
                    mac_en = 1'b1;
                    addr_d = addr_q + AW'(step_q);
                    rsel_d = ~rsel_q;
                    // high half consumed: move on to the next register of the pair
                    if (rsel_q)
                        ridx_d = ridx_q + 1'b1;
                    if (count1) begin
                        if (DRAIN == 0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = DCW'(DRAIN - 1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0)
                    state_d = S_DONE;
                else
                    drain_d = drain_q - 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr = addr_q;
    assign ridx     = ridx_q;
    assign rsel_hi  = rsel_q;

`ifdef MMULT_STALLCNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_LOAD)
            stall_d = '0;
        else if ((state_q == S_RUN) && !mem_ack && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mmult_seq.sv
// Self-checking bench for mmult_seq: scoreboard of expected read beats plus a
// per-cycle protocol monitor; includes a model of the external element counter.
module tb_mmult_seq;
    localparam int AW = 24;
    localparam int RW = 5;
    localparam int DRAIN = 2;

    logic          clk = 1'b0;
    logic          reset, go, mtxc_col, count1, mem_ack;
    logic [AW-1:0] mtxa;
    logic [3:0]    mwidth;
    logic [RW-1:0] rbase;
    logic          cntld, cnten, mem_req, rsel_hi, mac_clr, mac_en, busy, done;
    logic [AW-1:0] mem_addr;
    logic [RW-1:0] ridx;
`ifdef MMULT_STALLCNT_EN
    logic [15:0]   stall_cnt;
`endif

    mmult_seq #(.AW(AW), .RW(RW), .DRAIN(DRAIN)) dut (
        .clk(clk), .reset(reset), .go(go), .mtxa(mtxa), .mtxc_col(mtxc_col),
        .mwidth(mwidth), .rbase(rbase), .count1(count1), .mem_ack(mem_ack),
        .cntld(cntld), .cnten(cnten), .mem_req(mem_req), .mem_addr(mem_addr),
        .ridx(ridx), .rsel_hi(rsel_hi), .mac_clr(mac_clr), .mac_en(mac_en),
        .busy(busy), .done(done)
`ifdef MMULT_STALLCNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // external 4-bit element counter
    logic [3:0] cnt_m;
    always @(posedge clk or posedge reset) begin
        if (reset)      cnt_m <= 4'd0;
        else if (cntld) cnt_m <= mwidth;
        else if (cnten) cnt_m <= cnt_m - 4'd1;
    end
    assign count1 = (cnt_m == 4'd1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] ridx;
        logic          hi;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int n_acc, n_cnten, n_macen, n_done, n_stall, done_cyc;
    bit done_prev, clr_seen;

    // monitor: scoreboard pops on accepted beats plus protocol rules
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && mem_ack) begin
                n_acc++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: accept at addr %h ridx %0d hi %0d, none expected", mem_addr, ridx, rsel_hi);
                end else begin
                    mon_e = sb.pop_front();
                    if ({mem_addr, ridx, rsel_hi} !== mon_e) begin
                        n_fail++;
                        $display("FAIL sb_beat: got addr %h ridx %0d hi %0d, expected addr %h ridx %0d hi %0d",
                                 mem_addr, ridx, rsel_hi, mon_e.addr, mon_e.ridx, mon_e.hi);
                    end
                end
            end
            if (cnten) n_cnten++;
            if (mac_en) n_macen++;
            if (mem_req && !mem_ack) n_stall++;
            if (done) begin n_done++; done_cyc = cyc; end
            n_checks++;
            if (cntld && (cnten || mem_req || done || !mac_clr || !busy)) begin
                n_fail++;
                $display("FAIL proto_cntld: cntld=1 with cnten=%0d mem_req=%0d done=%0d mac_clr=%0d busy=%0d",
                         cnten, mem_req, done, mac_clr, busy);
            end
            n_checks++;
            if (cnten !== (mem_req & mem_ack) || mac_en !== cnten) begin
                n_fail++;
                $display("FAIL proto_cnten: cnten=%0d mac_en=%0d, expected both %0d", cnten, mac_en, mem_req & mem_ack);
            end
            if (mac_clr) clr_seen = 1'b1;
            n_checks++;
            if (mac_en && !clr_seen) begin
                n_fail++;
                $display("FAIL proto_clr_order: mac_en=1 before mac_clr, expected mac_clr first");
            end
            n_checks++;
            if (done && done_prev) begin
                n_fail++;
                $display("FAIL proto_done_len: done high 2 cycles, expected 1");
            end
            n_checks++;
            if ((done || mem_req || cntld || mac_clr) && !busy) begin
                n_fail++;
                $display("FAIL proto_busy: busy=0 while active, expected 1");
            end
            if (done) clr_seen = 1'b0;
            done_prev = done;
        end else begin
            done_prev = 1'b0;
            clr_seen  = 1'b0;
        end
    end

    task automatic clear_counts();
        n_acc = 0; n_cnten = 0; n_macen = 0; n_done = 0; n_stall = 0;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [3:0] mw, input logic col, input logic [RW-1:0] rb);
        int n, step;
        exp_t e;
        n = (mw == 4'd0) ? 16 : int'(mw);
        step = col ? n * 4 : 4;
        for (int i = 0; i < n; i++) begin
            e.addr = (a & ~AW'(3)) + AW'(i * step);
            e.ridx = rb + RW'(i / 2);
            e.hi   = i[0];
            sb.push_back(e);
        end
    endtask

    // drives one operation to completion; lat = cycles from go cycle to done cycle inclusive
    task automatic do_op(input logic [AW-1:0] a, input logic [3:0] mw, input logic col,
                         input logic [RW-1:0] rb, input int stall_len, input bit go_mid, output int lat);
        int stall_left, runc, g_cyc;
        bit seen;
        push_exp(a, mw, col, rb);
        mtxa = a; mwidth = mw; mtxc_col = col; rbase = rb; go = 1'b1; mem_ack = 1'b1;
        g_cyc = cyc; stall_left = stall_len; runc = 0; seen = 0; lat = -1;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk); #1;
            go = 1'b0;
            if (done) begin
                seen = 1;
                lat = cyc - g_cyc + 1;
            end else if (mem_req) begin
                runc++;
                if (go_mid && runc == 2) begin
                    go = 1'b1; mtxa = ~a; rbase = ~rb; mtxc_col = ~col;
                end
                mem_ack = (stall_left > 0) ? 1'b0 : 1'b1;
                if (stall_left > 0) stall_left--;
            end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL op_timeout: no done within 300 cycles, expected done");
        end
        go = 1'b0; mem_ack = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; go = 1'b0; mtxa = '0; mtxc_col = 1'b0; mwidth = 4'd0; rbase = '0; mem_ack = 1'b0;
        #1;
        n_checks++;
        if ({cntld, cnten, mem_req, rsel_hi, mac_clr, mac_en, busy, done} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 00000000", {cntld, cnten, mem_req, rsel_hi, mac_clr, mac_en, busy, done});
        end
        n_checks++;
        if (mem_addr !== '0 || ridx !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got addr %h ridx %0d, expected 0 0", mem_addr, ridx);
        end
`ifdef MMULT_STALLCNT_EN
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt: got %0d, expected 0", stall_cnt);
        end
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_row();
        int lat;
        clear_counts();
        do_op(24'hF03000, 4'd3, 1'b0, 5'd4, 0, 0, lat);
        n_checks++;
        if (n_acc !== 3 || n_macen !== 3 || n_cnten !== 3) begin
            n_fail++;
            $display("FAIL row_counts: got acc %0d mac_en %0d cnten %0d, expected 3 3 3", n_acc, n_macen, n_cnten);
        end
        n_checks++;
        if (lat !== 8) begin n_fail++; $display("FAIL row_latency: got %0d, expected 8", lat); end
        n_checks++;
        if (n_done !== 1 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL row_done: got done %0d left %0d, expected 1 0", n_done, sb.size());
        end
    endtask

    task automatic test_col();
        int lat;
        clear_counts();
        do_op(24'hF03010, 4'd4, 1'b1, 5'd10, 0, 0, lat);
        n_checks++;
        if (n_acc !== 4 || lat !== 9 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL col_op: got acc %0d lat %0d left %0d, expected 4 9 0", n_acc, lat, sb.size());
        end
    endtask

    task automatic test_full_wrap();
        int lat;
        clear_counts();
        do_op(24'hFFFFF8, 4'd0, 1'b0, 5'd31, 0, 0, lat);
        n_checks++;
        if (n_acc !== 16 || n_cnten !== 16) begin
            n_fail++;
            $display("FAIL full_counts: got acc %0d cnten %0d, expected 16 16", n_acc, n_cnten);
        end
        n_checks++;
        if (lat !== 21) begin n_fail++; $display("FAIL full_latency: got %0d, expected 21", lat); end
        n_checks++;
        if (mem_addr !== 24'h000038) begin
            n_fail++;
            $display("FAIL full_wrap_addr: got %h, expected 000038", mem_addr);
        end
    endtask

    task automatic test_single();
        int lat;
        clear_counts();
        do_op(24'h000123, 4'd1, 1'b1, 5'd0, 0, 0, lat);
        n_checks++;
        if (n_acc !== 1 || lat !== 6 || mem_addr !== 24'h000124) begin
            n_fail++;
            $display("FAIL single_op: got acc %0d lat %0d addr %h, expected 1 6 000124", n_acc, lat, mem_addr);
        end
    endtask

    task automatic test_stall();
        int lat;
        clear_counts();
        do_op(24'h00A000, 4'd2, 1'b0, 5'd7, 5, 0, lat);
        n_checks++;
        if (n_stall !== 5 || n_acc !== 2 || n_cnten !== 2) begin
            n_fail++;
            $display("FAIL stall_counts: got stall %0d acc %0d cnten %0d, expected 5 2 2", n_stall, n_acc, n_cnten);
        end
        n_checks++;
        if (lat !== 12) begin n_fail++; $display("FAIL stall_latency: got %0d, expected 12", lat); end
`ifdef MMULT_STALLCNT_EN
        n_checks++;
        if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_cnt: got %0d, expected 5", stall_cnt); end
`endif
    endtask

    task automatic test_go_mid();
        int lat;
        clear_counts();
        do_op(24'h123450, 4'd3, 1'b0, 5'd2, 0, 1, lat);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (n_done !== 1 || n_acc !== 3 || busy !== 1'b0 || lat !== 8) begin
            n_fail++;
            $display("FAIL go_mid: got done %0d acc %0d busy %0d lat %0d, expected 1 3 0 8", n_done, n_acc, busy, lat);
        end
    endtask

    task automatic test_reset_mid();
        int runc;
        clear_counts();
        push_exp(24'h0F0000, 4'd4, 1'b0, 5'd3);
        mtxa = 24'h0F0000; mwidth = 4'd4; mtxc_col = 1'b0; rbase = 5'd3; go = 1'b1; mem_ack = 1'b1;
        runc = 0;
        for (int k = 0; k < 20 && runc < 2; k++) begin
            @(posedge clk); #1;
            go = 1'b0;
            if (mem_req) runc++;
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({cntld, cnten, mem_req, rsel_hi, mac_clr, mac_en, busy, done} !== 8'b0 || mem_addr !== '0 || ridx !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got flags %b addr %h ridx %0d, expected all 0",
                     {cntld, cnten, mem_req, rsel_hi, mac_clr, mac_en, busy, done}, mem_addr, ridx);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (n_done !== 0 || busy !== 1'b0 || n_acc !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_after: got done %0d busy %0d acc %0d, expected 0 0 1", n_done, busy, n_acc);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        clear_counts();
        do_op(24'h200000, 4'd2, 1'b1, 5'd30, 0, 0, lat1);
        do_op(24'h300004, 4'd5, 1'b0, 5'd1, 2, 0, lat2);
        n_checks++;
        if (n_done !== 2 || n_acc !== 7 || lat1 !== 7 || lat2 !== 12 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL back_to_back: got done %0d acc %0d lat %0d/%0d left %0d, expected 2 7 7/12 0",
                     n_done, n_acc, lat1, lat2, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_row();
        test_col();
        test_full_wrap();
        test_single();
        test_stall();
        test_go_mid();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
